// File: rtl/gl_cmd_writer.sv
// Packs GL command headers and operands into instruction BRAM at the per-opcode stride.
// Optional list terminator write on close: define GL_CMD_WRITER_TERM_EN.
module gl_cmd_writer #(
  parameter int unsigned TEXT_START = 0,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 1024
`ifdef GL_CMD_WRITER_TERM_EN
  ,
  parameter logic [WIDTH-1:0] TERM_WORD = WIDTH'(32'h000000FF)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_word,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_data,
  input  logic             list_end,
  output logic             bram_we,
  output logic [WIDTH-1:0] bram_addr,
  output logic [WIDTH-1:0] bram_wdata,
  output logic [WIDTH-1:0] wr_ptr,
  output logic [15:0]      cmd_count,
  output logic             busy,
  output logic             overflow,
  output logic             list_done
);

`ifdef GL_CMD_WRITER_TERM_EN
  localparam int unsigned TERM_RES = 1;
`else
  localparam int unsigned TERM_RES = 0;
`endif
  localparam logic [WIDTH-1:0] BASE  = WIDTH'(TEXT_START);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TEXT_START + DEPTH - TERM_RES);

  typedef enum logic [1:0] {IDLE, OPER, DRAIN, CLOSE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       rem_q, rem_d;
  logic [WIDTH-1:0] wr_ptr_d, addr_d, wdata_d;
  logic [15:0]      cmd_count_d;
  logic             we_d, overflow_d, done_d;
  logic [4:0]       fp, n_ops;
  logic             fits;

  function automatic logic [4:0] footprint(input logic [7:0] opc);
    case (opc)
      8'h03, 8'h04:                      return 5'd4;
      8'h11, 8'h13, 8'h16, 8'h17, 8'h18: return 5'd17;
      8'h19:                             return 5'd5;
      8'h1A:                             return 5'd7;
      default:                           return 5'd1;
    endcase
  endfunction

  assign fp    = footprint(cmd_word[7:0]);
  assign n_ops = fp - 5'd1;
  assign fits  = (wr_ptr + WIDTH'(fp)) <= LIMIT;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wr_ptr_d    = wr_ptr;
    cmd_count_d = cmd_count;
    overflow_d  = overflow;
    we_d        = 1'b0;
    addr_d      = bram_addr;
    wdata_d     = bram_wdata;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (list_end) begin
          state_d = CLOSE;
`ifdef GL_CMD_WRITER_TERM_EN
          we_d    = 1'b1;
          addr_d  = wr_ptr;
          wdata_d = TERM_WORD;
`else
          done_d      = 1'b1;
          wr_ptr_d    = BASE;
          cmd_count_d = 16'd0;
          overflow_d  = 1'b0;
`endif
        end else if (cmd_valid && cmd_ready) begin
          rem_d = n_ops;
          if (fits) begin
            we_d        = 1'b1;
            addr_d      = wr_ptr;
            wdata_d     = cmd_word;
            wr_ptr_d    = wr_ptr + 1'b1;
            cmd_count_d = cmd_count + 16'd1;
            if (n_ops != 5'd0) state_d = OPER;
          end else begin
            // Rejected command still owns its operands; swallow them to stay aligned
            overflow_d = 1'b1;
            if (n_ops != 5'd0) state_d = DRAIN;
          end
        end
      end
      OPER: begin
        if (op_valid && op_ready) begin
          we_d     = 1'b1;
          addr_d   = wr_ptr;
          wdata_d  = op_data;
          wr_ptr_d = wr_ptr + 1'b1;
          rem_d    = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (op_valid && op_ready) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = IDLE;
        end
      end
      CLOSE: begin
        state_d = IDLE;
`ifdef GL_CMD_WRITER_TERM_EN
        done_d      = 1'b1;
        wr_ptr_d    = BASE;
        cmd_count_d = 16'd0;
        overflow_d  = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= 5'd0;
      bram_we    <= 1'b0;
      bram_addr  <= BASE;
      bram_wdata <= '0;
      wr_ptr     <= BASE;
      cmd_count  <= 16'd0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      list_done  <= 1'b0;
      cmd_ready  <= 1'b1;
      op_ready   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      bram_we    <= we_d;
      bram_addr  <= addr_d;
      bram_wdata <= wdata_d;
      wr_ptr     <= wr_ptr_d;
      cmd_count  <= cmd_count_d;
      busy       <= (state_d != IDLE);
      overflow   <= overflow_d;
      list_done  <= done_d;
      cmd_ready  <= (state_d == IDLE);
      op_ready   <= (state_d == OPER) || (state_d == DRAIN);
    end
  end

endmodule

// File: tb/tb_gl_cmd_writer.sv
// Bench for gl_cmd_writer: table vectors, corner sequences and randomized commands vs a word-level model.
module tb_gl_cmd_writer;
  localparam int DEPTH = 32;
`ifdef GL_CMD_WRITER_TERM_EN
  localparam int TERM_EN = 1;
`else
  localparam int TERM_EN = 0;
`endif
  localparam int CAP = DEPTH - TERM_EN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, op_valid = 1'b0, list_end = 1'b0;
  logic [31:0] cmd_word = '0, op_data = '0;
  logic        cmd_ready, op_ready, bram_we, busy, overflow, list_done;
  logic [31:0] bram_addr, bram_wdata, wr_ptr;
  logic [15:0] cmd_count;

  gl_cmd_writer #(.TEXT_START(0), .WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .list_end(list_end),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .wr_ptr(wr_ptr), .cmd_count(cmd_count), .busy(busy),
    .overflow(overflow), .list_done(list_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int max_run = 0;
  int run_len = 0;

  // model: expected BRAM writes in order, plus list bookkeeping
  logic [63:0] exp_q[$];
  int m_ptr = 0, m_cnt = 0;
  bit m_ovf = 1'b0, m_drain = 1'b0;

  typedef struct {
    logic [31:0] cmd;
    int          nops;
    int          ptr;
    int          cnt;
    logic        ovf;
  } vec_t;
  vec_t tbl[8];

  function automatic int fp_of(input logic [7:0] opc);
    if (opc == 8'h03 || opc == 8'h04) return 4;
    if (opc == 8'h11 || opc == 8'h13 || opc == 8'h16 || opc == 8'h17 || opc == 8'h18) return 17;
    if (opc == 8'h19) return 5;
    if (opc == 8'h1A) return 7;
    return 1;
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (bram_we) begin
      run_len++;
      if (exp_q.size() == 0) chk("unexpected_write", 32'(bram_we), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", bram_addr, e[63:32]);
        chk("wr_data", bram_wdata, e[31:0]);
      end
    end else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_ovf = 1'b0; m_drain = 1'b0;
  endtask

  task automatic xfer_cmd(input logic [31:0] w);
    int k = 0;
    int f;
    cmd_valid = 1'b1;
    cmd_word  = w;
    while (!cmd_ready && k < 50) begin tick(); k++; end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    f = fp_of(w[7:0]);
    if (m_ptr + f <= CAP) begin
      exp_q.push_back({32'(m_ptr), w});
      m_ptr++; m_cnt++; m_drain = 1'b0;
    end else begin
      m_ovf = 1'b1; m_drain = 1'b1;
    end
    @(posedge clk);
    tick();
    cmd_valid = 1'b0;
    chk("busy_after_hdr", 32'(busy), 32'(f > 1));
  endtask

  task automatic xfer_op(input logic [31:0] d);
    int k = 0;
    op_valid = 1'b1;
    op_data  = d;
    while (!op_ready && k < 50) begin tick(); k++; end
    if (!op_ready) begin
      chk("op_ready_timeout", 32'(op_ready), 32'd1);
      return;
    end
    if (!m_drain) begin
      exp_q.push_back({32'(m_ptr), d});
      m_ptr++;
    end
    @(posedge clk);
    tick();
  endtask

  task automatic run_cmd(input logic [31:0] w, input int nops, input logic [31:0] base, input bit gaps);
    xfer_cmd(w);
    for (int i = 0; i < nops; i++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        op_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      xfer_op(base + 32'(i) + 32'd1);
    end
    op_valid = 1'b0;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("m_wr_ptr", wr_ptr, 32'(m_ptr));
    chk("m_cmd_count", 32'(cmd_count), 32'(m_cnt));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_close(input bit with_cmd);
    int k = 1;
    if (TERM_EN != 0) exp_q.push_back({32'(m_ptr), 32'h000000FF});
    list_end  = 1'b1;
    cmd_valid = with_cmd;
    cmd_word  = 32'h00000003;
    tick();
    list_end  = 1'b0;
    cmd_valid = 1'b0;
    while (!list_done && k < 8) begin tick(); k++; end
    chk("list_done_latency", 32'(k), 32'(1 + TERM_EN));
    chk("close_wr_ptr", wr_ptr, 32'd0);
    chk("close_cmd_count", 32'(cmd_count), 32'd0);
    chk("close_overflow", 32'(overflow), 32'd0);
    model_reset();
    tick();
    chk("list_done_pulse", 32'(list_done), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(bram_we), 32'd0);
    chk({tag, "_addr"}, bram_addr, 32'd0);
    chk({tag, "_wdata"}, bram_wdata, 32'd0);
    chk({tag, "_wr_ptr"}, wr_ptr, 32'd0);
    chk({tag, "_cnt"}, 32'(cmd_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_done"}, 32'(list_done), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
  endtask

  initial begin
    logic [7:0] opc;
    logic [7:0] op_choices[9];

    tbl[0] = '{32'h00000003, 3, 4, 1, 1'b0};
    tbl[1] = '{32'h00000001, 0, 5, 2, 1'b0};
    tbl[2] = '{32'h00000019, 4, 10, 3, 1'b0};
    tbl[3] = '{32'h00000013, 16, 27, 4, 1'b0};
    tbl[4] = '{32'h0000001A, 6, 27, 4, 1'b1};
    tbl[5] = '{32'h00000004, 3, 31, 5, 1'b1};
    if (TERM_EN != 0) begin
      tbl[6] = '{32'h123456AB, 0, 31, 5, 1'b1};
      tbl[7] = '{32'h00000005, 0, 31, 5, 1'b1};
    end else begin
      tbl[6] = '{32'h123456AB, 0, 32, 6, 1'b1};
      tbl[7] = '{32'h00000005, 0, 32, 6, 1'b1};
    end
    op_choices = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};

    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].cmd, tbl[i].nops, 32'(i) << 8, i != 3);
      chk("tbl_wr_ptr", wr_ptr, 32'(tbl[i].ptr));
      chk("tbl_cmd_count", 32'(cmd_count), 32'(tbl[i].cnt));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
    end

    do_close(1'b0);

    // load matrix: 17 back-to-back writes, next header right behind
    max_run = 0;
    run_cmd(32'h00000013, 16, 32'h00001000, 1'b0);
    chk("load_run", 32'(max_run), 32'd17);
    run_cmd(32'h00000001, 0, 32'h0, 1'b0);
    chk("load_next_ptr", wr_ptr, 32'd18);

    // list_end wins over a same-cycle header
    do_close(1'b1);
    chk("prio_cnt", 32'(cmd_count), 32'd0);

    // reset abandons a half-written load matrix
    xfer_cmd(32'h00000013);
    for (int i = 0; i < 5; i++) xfer_op(32'h00002000 + 32'(i));
    #2 reset = 1'b1;
    #1;
    op_valid = 1'b0;
    chk_reset_vals("async_rst");
    exp_q.delete();
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_cmd(32'h00000001, 0, 32'h0, 1'b0);
    chk("post_rst_ptr", wr_ptr, 32'd1);

    for (int r = 0; r < 60; r++) begin
      if ($urandom % 8 == 0) do_close(1'($urandom % 2));
      else begin
        if ($urandom % 4 == 0) opc = 8'($urandom);
        else opc = op_choices[$urandom_range(0, 8)];
        run_cmd({24'($urandom), opc}, fp_of(opc) - 1, $urandom, 1'b1);
      end
    end

    tick();
    tick();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
